// File: rtl/ram_bist_sequencer_if.sv
// RAM port bundle between the BIST sequencer (master) and the single-port synchronous RAM (slave).
interface ram_bist_sequencer_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0] ram_data;
   logic                  ram_wren;
   logic [DATA_WIDTH-1:0] ram_q;

   modport master (output ram_address, output ram_data, output ram_wren, input ram_q);
   modport slave  (input ram_address, input ram_data, input ram_wren, output ram_q);
endinterface

// File: rtl/ram_bist_sequencer.sv
// Fill-then-verify sequencer for a single-port synchronous RAM: writes a pattern to every
// address, reads everything back through a one-stage pipeline and reports the mismatches.
module ram_bist_sequencer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] pattern_in,
   input  logic                  verify_only,
   ram_bist_sequencer_if.master  ram,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH:0]   error_count,
   output logic                  fail_valid,
   output logic [ADDR_WIDTH-1:0] first_fail_addr
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_wren;
   logic [1:0]            r_mode;
   logic [DATA_WIDTH-1:0] r_pattern;
   logic                  r_verify_only;
   logic                  r_pvalid;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [ADDR_WIDTH:0]   r_err;
   logic                  r_fail_valid;
   logic [ADDR_WIDTH-1:0] r_first_fail;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_pass;

   logic [2:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic                  w_wren_nxt;
   logic                  w_start;
   logic [1:0]            w_mode_sel;
   logic [DATA_WIDTH-1:0] w_pat_sel;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic                  w_mismatch;
   logic [ADDR_WIDTH:0]   w_err_nxt;

   // Expected word for an address under a given pattern mode
   function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [1:0] m,
                                                       input logic [DATA_WIDTH-1:0] p,
                                                       input logic [ADDR_WIDTH-1:0] a);
      case (m)
         2'd0:    f_pattern = p;
         2'd1:    f_pattern = '0;
         2'd2:    f_pattern = '1;
         2'd3:    f_pattern = {~a, a};
         default: f_pattern = '0;
      endcase
   endfunction

   // Next-state, address and write-enable decode
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr + ADDR_ONE;
      w_wren_nxt  = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_addr_nxt = '0;
            if (start) begin
               w_start = 1'b1;
               if (verify_only) begin
                  w_state_nxt = S_READ;
               end else begin
                  w_state_nxt = S_WRITE;
                  w_wren_nxt  = 1'b1;
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_WRITE: begin
            if (r_addr == ADDR_LAST) begin
               w_state_nxt = S_READ;
            end else begin
               w_wren_nxt = 1'b1;
            end
         end
         S_READ: begin
            if (r_addr == ADDR_LAST) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_DONE;
            w_addr_nxt  = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
         end
      endcase
   end

   // Pattern selection for the next write word and compare of the returning read data
   always_comb begin
      if (w_start) begin
         w_mode_sel = mode;
         w_pat_sel  = pattern_in;
      end else begin
         w_mode_sel = r_mode;
         w_pat_sel  = r_pattern;
      end
      w_data_nxt = f_pattern(w_mode_sel, w_pat_sel, w_addr_nxt);
      w_mismatch = r_pvalid && (ram.ram_q != f_pattern(r_mode, r_pattern, r_paddr));
      w_err_nxt  = r_err + {{ADDR_WIDTH{1'b0}}, w_mismatch};
   end

   // State, RAM drive, read pipeline and result registers
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_data        <= '0;
         r_wren        <= 1'b0;
         r_mode        <= 2'd0;
         r_pattern     <= '0;
         r_verify_only <= 1'b0;
         r_pvalid      <= 1'b0;
         r_paddr       <= '0;
         r_err         <= '0;
         r_fail_valid  <= 1'b0;
         r_first_fail  <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_data   <= w_data_nxt;
         r_wren   <= w_wren_nxt;
         r_pvalid <= (r_state == S_READ);
         r_paddr  <= r_addr;
         if (w_start) begin
            r_mode        <= mode;
            r_pattern     <= pattern_in;
            r_verify_only <= verify_only;
            r_err         <= '0;
            r_fail_valid  <= 1'b0;
            r_first_fail  <= '0;
            r_pass        <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b1;
         end else begin
            r_err <= w_err_nxt;
            if (w_mismatch && !r_fail_valid) begin
               r_fail_valid <= 1'b1;
               r_first_fail <= r_paddr;
            end
            // The drain compare is folded into the pass verdict as done rises
            if (r_state == S_DRAIN) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (w_err_nxt == '0);
            end
         end
      end
   end

   assign ram.ram_address  = r_addr;
   assign ram.ram_data     = r_data;
   assign ram.ram_wren     = r_wren;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign error_count      = r_err;
   assign fail_valid       = r_fail_valid;
   assign first_fail_addr  = r_first_fail;
endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Bench for ram_bist_sequencer: directed vector table, hand-written corner sequences and
// randomized runs against a RAM model with injectable read faults.
module tb_ram_bist_sequencer;
   logic       clock = 1'b0;
   logic       clear;
   logic       start;
   logic [1:0] mode;
   logic [7:0] pattern_in;
   logic       verify_only;
   logic       busy, done, pass, fail_valid;
   logic [4:0] error_count;
   logic [3:0] first_fail_addr;

   ram_bist_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) rif ();

   ram_bist_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clock(clock), .clear(clear), .start(start), .mode(mode), .pattern_in(pattern_in),
      .verify_only(verify_only), .ram(rif), .busy(busy), .done(done), .pass(pass),
      .error_count(error_count), .fail_valid(fail_valid), .first_fail_addr(first_fail_addr)
   );

   always #5 clock = ~clock;

   logic [7:0]  mem [16];
   logic [15:0] fault_mask = 16'h0000;
   logic [7:0]  fault_val  = 8'h00;
   logic [7:0]  last_a5;
   int          n_checks = 0;
   int          n_errors = 0;

   // RAM model: registered address/data, read data one cycle later, faulty addresses read fault_val
   always @(posedge clock) begin
      if (rif.ram_wren) mem[rif.ram_address] <= rif.ram_data;
      rif.ram_q <= fault_mask[rif.ram_address] ? fault_val : mem[rif.ram_address];
   end

   typedef struct {
      logic [1:0]  mode;
      logic [7:0]  pat;
      logic        vo;
      logic        pulses;
      logic [15:0] fmask;
      int          exp_cycle;
      logic        exp_pass;
      int          exp_err;
      logic        exp_fv;
      int          exp_ffa;
      int          exp_wren;
   } vec_t;

   vec_t tbl [5];

   function automatic logic [7:0] ref_pat(input logic [1:0] m, input logic [7:0] p, input int a);
      case (m)
         2'd0:    return p;
         2'd1:    return 8'h00;
         2'd2:    return 8'hFF;
         default: return 8'(((15 - a) * 16) + a);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_run(input vec_t v, input string nm);
      int wren_cnt = 0;
      int wr_bad   = 0;
      int done_cyc = 0;
      fault_mask = v.fmask;
      last_a5    = 8'h00;
      @(negedge clock);
      start = 1'b1; mode = v.mode; pattern_in = v.pat; verify_only = v.vo;
      @(posedge clock);
      #1 start = 1'b0;
      for (int k = 1; k <= 80 && done_cyc == 0; k++) begin
         @(negedge clock);
         start = (v.pulses && (k == 5 || k == 20)) ? 1'b1 : 1'b0;
         if (rif.ram_wren) begin
            if (int'(rif.ram_address) != wren_cnt ||
                rif.ram_data !== ref_pat(v.mode, v.pat, int'(rif.ram_address))) wr_bad++;
            if (rif.ram_address == 4'h5) last_a5 = rif.ram_data;
            wren_cnt++;
         end
         if (done) done_cyc = k;
      end
      start = 1'b0;
      chk({nm, "_done_cycle"}, done_cyc, v.exp_cycle);
      chk({nm, "_pass"}, pass, v.exp_pass);
      chk({nm, "_error_count"}, error_count, v.exp_err);
      chk({nm, "_fail_valid"}, fail_valid, v.exp_fv);
      chk({nm, "_first_fail_addr"}, first_fail_addr, v.exp_ffa);
      chk({nm, "_wren_cycles"}, wren_cnt, v.exp_wren);
      chk({nm, "_write_words"}, wr_bad, 0);
      chk({nm, "_busy_low"}, busy, 0);
   endtask

   initial begin
      vec_t rv;
      int   cnt, first;
      logic [7:0] after, rd;
      bit   found;

      tbl[0] = '{2'd3, 8'h00, 1'b0, 1'b0, 16'h0000, 34, 1'b1, 0,  1'b0, 0, 16};
      tbl[1] = '{2'd0, 8'h3C, 1'b0, 1'b0, 16'h1080, 34, 1'b0, 2,  1'b1, 7, 16};
      tbl[2] = '{2'd2, 8'h00, 1'b0, 1'b1, 16'h0000, 34, 1'b1, 0,  1'b0, 0, 16};
      tbl[3] = '{2'd2, 8'h00, 1'b1, 1'b0, 16'h0000, 18, 1'b1, 0,  1'b0, 0, 0};
      tbl[4] = '{2'd1, 8'h00, 1'b1, 1'b0, 16'h0000, 18, 1'b0, 16, 1'b1, 0, 0};

      clear = 1'b1; start = 1'b0; mode = 2'd0; pattern_in = 8'h00; verify_only = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset_outputs", {busy, done, pass, fail_valid, rif.ram_wren}, 0);
      chk("reset_counts", {error_count, first_fail_addr, rif.ram_address, rif.ram_data}, 0);
      clear = 1'b0;

      for (int i = 0; i < 5; i++) begin
         do_run(tbl[i], $sformatf("vec%0d", i));
         if (i == 0) chk("mode3_addr5_word", last_a5, 8'hA5);
      end

      // Clear in the middle of the write phase
      fault_mask = 16'h0000;
      found = 1'b0;
      @(negedge clock);
      start = 1'b1; mode = 2'd3; verify_only = 1'b0;
      @(posedge clock);
      #1 start = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clock);
         if (rif.ram_wren && rif.ram_address == 4'h9) found = 1'b1;
      end
      chk("clear_reach_addr9", found, 1);
      clear = 1'b1;
      @(negedge clock);
      chk("clear_wren", rif.ram_wren, 0);
      chk("clear_busy", busy, 0);
      chk("clear_all_outputs",
          {done, pass, fail_valid, error_count, first_fail_addr, rif.ram_address, rif.ram_data}, 0);
      clear = 1'b0;
      @(negedge clock);
      chk("clear_stays_idle", {busy, rif.ram_wren}, 0);

      // start held high through DONE: back-to-back runs
      fault_mask = 16'h1080; fault_val = 8'h00;
      @(negedge clock);
      start = 1'b1; mode = 2'd0; pattern_in = 8'h3C; verify_only = 1'b0;
      @(posedge clock);
      #1;
      found = 1'b0;
      for (int k = 1; k <= 60 && !found; k++) begin
         @(negedge clock);
         if (done) begin
            found = 1'b1;
            chk("hold_run1_done_cycle", k, 34);
         end
      end
      chk("hold_run1_done_seen", found, 1);
      chk("hold_run1_error_count", error_count, 2);
      chk("hold_run1_first_fail", first_fail_addr, 7);
      mode = 2'd3; fault_mask = 16'h0000;
      @(negedge clock);
      chk("hold_run2_started", {busy, done, rif.ram_wren}, 3'b101);
      chk("hold_run2_count_cleared", error_count, 0);
      start = 1'b0;
      found = 1'b0;
      for (int k = 36; k <= 100 && !found; k++) begin
         @(negedge clock);
         if (done) begin
            found = 1'b1;
            chk("hold_run2_done_cycle", k, 68);
         end
      end
      chk("hold_run2_done_seen", found, 1);
      chk("hold_run2_results", {pass, fail_valid, error_count}, 7'b1000000);

      // Randomized runs checked against a whole-memory reference computation
      for (int r = 0; r < 8; r++) begin
         rv.mode   = 2'($urandom_range(0, 3));
         rv.pat    = 8'($urandom);
         rv.vo     = 1'($urandom_range(0, 1));
         rv.pulses = 1'($urandom_range(0, 1));
         rv.fmask  = 16'($urandom & $urandom & $urandom);
         fault_val = 8'($urandom);
         cnt = 0; first = -1;
         for (int a = 0; a < 16; a++) begin
            after = rv.vo ? mem[a] : ref_pat(rv.mode, rv.pat, a);
            rd    = rv.fmask[a] ? fault_val : after;
            if (rd !== ref_pat(rv.mode, rv.pat, a)) begin
               cnt++;
               if (first < 0) first = a;
            end
         end
         rv.exp_cycle = rv.vo ? 18 : 34;
         rv.exp_wren  = rv.vo ? 0 : 16;
         rv.exp_err   = cnt;
         rv.exp_pass  = (cnt == 0);
         rv.exp_fv    = (cnt != 0);
         rv.exp_ffa   = (first < 0) ? 0 : first;
         do_run(rv, $sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ram_bist_sequencer.md
Name: ram_bist_sequencer

Overview:
Controller that sequences the 16x8 single-port synchronous RAM through a fill-then-verify pass without manual clocking. On start it writes a selected pattern to every address. It then reads every address back and compares each word with the expected pattern, reporting done, pass/fail, error count and first failing address. It drives the RAM address, data and write-enable ports directly; the address and data outputs also feed the seven-segment decoders for display.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM word width; must equal 2*ADDR_WIDTH (mode 3 pattern)

Ports:
clock  in  1  system clock; all state on rising edge
clear  in  1  synchronous active-high reset
start  in  1  begin a run; sampled only in IDLE or DONE
mode  in  2  pattern select, latched at start: 0=pattern_in, 1=8'h00, 2=8'hFF, 3={~addr,addr}
pattern_in  in  DATA_WIDTH  user word for mode 0, latched at start
verify_only  in  1  latched at start; 1 = skip write phase, check existing contents
ram_q  in  DATA_WIDTH  RAM read data
ram_address  out  ADDR_WIDTH  RAM address
ram_data  out  DATA_WIDTH  RAM write data (expected pattern for current address)
ram_wren  out  1  RAM write enable, active high
busy  out  1  run in progress
done  out  1  run complete; held until next start or clear
pass  out  1  valid with done; 1 = zero mismatches
error_count  out  ADDR_WIDTH+1  mismatches in last run (0..DEPTH)
fail_valid  out  1  at least one mismatch captured
first_fail_addr  out  ADDR_WIDTH  address of first mismatch

Behaviour:
- Reset (clear=1 at an edge, any state): state IDLE; all outputs 0; latched mode, pattern and verify_only cleared. This applies mid-run: ram_wren is low from the cycle after the edge.
- RAM timing: address and data registered inside the RAM. ram_q for the address presented in cycle N is valid in cycle N+1.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE with start=1: latch mode, pattern_in and verify_only. Clear error_count, fail_valid, first_fail_addr, pass and done; set busy. Next state is WRITE, or READ if verify_only. ram_address=0.
- WRITE: ram_wren=1 and ram_data=pattern(ram_address) each cycle. ram_address increments each cycle. At DEPTH-1: ram_address wraps to 0 and the next state is READ.
- READ: ram_wren=0 and ram_address increments each cycle. A one-stage pipeline register holds the issued address and a valid bit. In each cycle where the valid bit is set, ram_q is compared with pattern(pipelined address). At DEPTH-1 the next state is DRAIN.
- DRAIN: one cycle; compares the last address (DEPTH-1). Next state DONE.
- Compare on mismatch: error_count += 1. If fail_valid=0, capture first_fail_addr and set fail_valid.
- DONE: busy=0, done=1, pass = (error_count==0). ram_address and ram_wren=0.
- pattern(a): mode0 latched pattern_in; mode1 all zeros; mode2 all ones; mode3 {~a, a}.
- start while busy is ignored. start held high in DONE immediately begins a new run.
- Latency from the start-sample edge: full run is DEPTH write + DEPTH read + 1 drain cycles; done rises at cycle 2*DEPTH+2 (34 for defaults). verify_only run: done at cycle DEPTH+2 (18).
- error_count cannot overflow: width ADDR_WIDTH+1 holds DEPTH.
- ram_data outside WRITE is don't-care but must be deterministic; drive pattern(ram_address).

Test Plan:
- Mode 3 full run with a correct RAM model: ram_wren high cycles 1–16; address 0x5 written with 0xA5; done at cycle 34; pass=1; error_count=0; fail_valid=0.
- Mode 0, pattern_in=0x3C, with the model forcing address 0x7 and 0xC to read 0x00: pass=0; error_count=2; first_fail_addr=0x7.
- Mode 2 fill, then verify_only=1 run with mode 2: no ram_wren pulses during the second run; done at cycle 18; pass=1.
- verify_only=1 run with mode 1 on a RAM filled with 0xFF: error_count=16 (0x10); first_fail_addr=0x0; pass=0.
- clear asserted in WRITE at address 0x9: next cycle ram_wren=0, busy=0, all outputs 0. start pulses during a run: no restart; done timing unchanged.
- start held high across DONE: a second run begins the cycle after done. Results from the second run replace those from the first, and error_count is reset at start.
